// File: rtl/pipe_delay_pkg.sv
// pipe_delay_pkg: shared constants and helpers for pipe_delay_line.
// Parity helper is only used when PIPE_DELAY_PARITY_EN is defined.
package pipe_delay_pkg;

    localparam int DEPTH_MAX = 64;
    localparam int PAR_W_MAX = 256;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAR_W_MAX-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/pipe_delay_stage.sv
// pipe_delay_stage: one data+valid register stage of pipe_delay_line.
// Optional stored parity bit under PIPE_DELAY_PARITY_EN.
module pipe_delay_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
`ifdef PIPE_DELAY_PARITY_EN
    input  logic             i_par,
    output logic             o_par,
`endif
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Flush drops valid only; data keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (en) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

`ifdef PIPE_DELAY_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (en && !flush) begin
            r_par <= i_par;
        end
    end

    assign o_par = r_par;
`endif

endmodule

// File: rtl/pipe_delay_line.sv
// pipe_delay_line: DEPTH-stage delay line with selectable tap, flush and occupancy.
// Define PIPE_DELAY_PARITY_EN for per-stage parity and a sticky parity_err output.
module pipe_delay_line
    import pipe_delay_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = sel_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic [SEL_W-1:0]       delay_sel,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic [DEPTH*WIDTH-1:0] taps,
    output logic [DEPTH-1:0]       tap_valid,
    output logic [SEL_W-1:0]       occupancy,
`ifdef PIPE_DELAY_PARITY_EN
    output logic                   parity_err,
`endif
    output logic                   sel_err
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_delay_line: DEPTH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_delay_line: WIDTH must be >= 1");
    end

    // Chain index 0 is din itself, index k is the output of stage k-1.
    logic [WIDTH-1:0] w_d [DEPTH+1];
    logic             w_v [DEPTH+1];
    logic [SEL_W-1:0] w_sel;
    logic [SEL_W-1:0] r_occ;

    assign w_d[0] = din;
    assign w_v[0] = din_valid;

`ifdef PIPE_DELAY_PARITY_EN
    logic w_p [DEPTH+1];
    logic w_sel_par;
    assign w_p[0] = even_parity(PAR_W_MAX'(din));
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .flush   (flush),
            .i_data  (w_d[i]),
            .i_valid (w_v[i]),
`ifdef PIPE_DELAY_PARITY_EN
            .i_par   (w_p[i]),
            .o_par   (w_p[i+1]),
`endif
            .o_data  (w_d[i+1]),
            .o_valid (w_v[i+1])
        );
        assign taps[i*WIDTH +: WIDTH] = w_d[i+1];
        assign tap_valid[i]           = w_v[i+1];
    end

    assign sel_err = (delay_sel > SEL_W'(DEPTH));
    assign w_sel   = sel_err ? SEL_W'(DEPTH) : delay_sel;

    always_comb begin
        dout       = w_d[0];
        dout_valid = w_v[0];
`ifdef PIPE_DELAY_PARITY_EN
        w_sel_par  = w_p[0];
`endif
        for (int i = 1; i <= DEPTH; i++) begin
            if (w_sel == SEL_W'(i)) begin
                dout       = w_d[i];
                dout_valid = w_v[i];
`ifdef PIPE_DELAY_PARITY_EN
                w_sel_par  = w_p[i];
`endif
            end
        end
    end

    // Incremental count: one word in, one word out per shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (en) begin
            r_occ <= r_occ + SEL_W'(din_valid) - SEL_W'(w_v[DEPTH]);
        end
    end

    assign occupancy = r_occ;

`ifdef PIPE_DELAY_PARITY_EN
    logic r_perr;
    logic w_perr_hit;

    assign w_perr_hit = (w_sel != '0) && dout_valid
                      && (even_parity(PAR_W_MAX'(dout)) != w_sel_par);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else if (flush) begin
            r_perr <= 1'b0;
        end else if (w_perr_hit) begin
            r_perr <= 1'b1;
        end
    end

    assign parity_err = r_perr;
`endif

    if (DEPTH <= DEPTH_MAX) begin : g_occ_chk
        always_ff @(posedge clk) begin
            if (rst_n) begin
                assert (r_occ == SEL_W'($countones(tap_valid)));
            end
        end
    end

endmodule

// File: tb/tb_pipe_delay_line.sv
// tb_pipe_delay_line: directed stimulus, queue-based reference model, per-cycle compare.
// Parity scenario runs only when PIPE_DELAY_PARITY_EN is defined.
module tb_pipe_delay_line;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic [2:0]  delay_sel = 3'd0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [31:0] taps;
    logic [3:0]  tap_valid;
    logic [2:0]  occupancy;
    logic        sel_err;
`ifdef PIPE_DELAY_PARITY_EN
    logic        parity_err;
`endif

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit cmp_off = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       v;
    } ent_t;

    ent_t m_pipe[$];

    pipe_delay_line #(
        .WIDTH (8),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .din        (din),
        .din_valid  (din_valid),
        .delay_sel  (delay_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .taps       (taps),
        .tap_valid  (tap_valid),
        .occupancy  (occupancy),
`ifdef PIPE_DELAY_PARITY_EN
        .parity_err (parity_err),
`endif
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the pipe is a queue, newest word at the front.
    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_pipe[i]) m_pipe[i] = '{d: 8'h00, v: 1'b0};
            chk_en = 1'b1;
        end else if (flush) begin
            foreach (m_pipe[i]) m_pipe[i].v = 1'b0;
        end else if (en) begin
            m_pipe.push_front('{d: din, v: din_valid});
            void'(m_pipe.pop_back());
        end
    end

    always @(negedge clk) begin : cmp
        ent_t        e;
        int          k;
        int          occ;
        logic [31:0] et;
        logic [3:0]  ev;
        if (chk_en && !cmp_off) begin
            k = (int'(delay_sel) > D) ? D : int'(delay_sel);
            if (k == 0) e = '{d: din, v: din_valid};
            else        e = m_pipe[k-1];
            occ = 0;
            for (int i = 0; i < D; i++) begin
                et[i*8 +: 8] = m_pipe[i].d;
                ev[i]        = m_pipe[i].v;
                occ         += int'(m_pipe[i].v);
            end
            check("m_dout", 32'(dout), 32'(e.d));
            check("m_dout_valid", 32'(dout_valid), 32'(e.v));
            check("m_taps", taps, et);
            check("m_tap_valid", 32'(tap_valid), 32'(ev));
            check("m_occupancy", 32'(occupancy), 32'(occ));
            check("m_sel_err", 32'(sel_err), 32'(int'(delay_sel) > D));
        end
    end

    initial begin
        for (int i = 0; i < D; i++) m_pipe.push_back('{d: 8'h00, v: 1'b0});

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        check("rst_tap_valid", 32'(tap_valid), 32'h0);
        check("rst_occ", 32'(occupancy), 32'h0);
        check("rst_taps", taps, 32'h0);

        // Single word, delay 3
        en = 1'b1;
        delay_sel = 3'd3;
        din = 8'hA5;
        din_valid = 1'b1;
        step();
        din = 8'h00;
        din_valid = 1'b0;
        check("a5_occ_1", 32'(occupancy), 32'd1);
        check("a5_early_1", 32'(dout_valid), 32'd0);
        step();
        check("a5_occ_2", 32'(occupancy), 32'd1);
        check("a5_early_2", 32'(dout_valid), 32'd0);
        step();
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_dout_valid", 32'(dout_valid), 32'd1);
        check("a5_occ_3", 32'(occupancy), 32'd1);
        step();
        check("a5_late", 32'(dout_valid), 32'd0);
        check("a5_occ_4", 32'(occupancy), 32'd1);
        step();
        check("a5_occ_exit", 32'(occupancy), 32'd0);

        // Continuous stream 1..6, delay 4
        delay_sel = 3'd4;
        for (int i = 0; i < 10; i++) begin
            din = 8'(i + 1);
            din_valid = (i < 6);
            step();
            if (i >= 3 && i <= 8) begin
                check("stream_dout", 32'(dout), 32'(i - 2));
                check("stream_valid", 32'(dout_valid), 32'd1);
            end
            if (i < 6)
                check("stream_occ", 32'(occupancy), 32'((i + 1 > 4) ? 4 : i + 1));
        end
        din_valid = 1'b0;

        // Fill three, stall five cycles, resume
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int j = 0; j < 3; j++) begin
            din = 8'(8'h10 + j);
            din_valid = 1'b1;
            step();
        end
        en = 1'b0;
        din = 8'h77;
        repeat (5) begin
            step();
            check("stall_taps", 32'(taps[23:0]), 32'h101112);
            check("stall_tap_valid", 32'(tap_valid), 32'h7);
            check("stall_occ", 32'(occupancy), 32'd3);
        end
        en = 1'b1;
        din = 8'h13;
        step();
        check("resume_taps", taps, 32'h10111213);
        check("resume_occ", 32'(occupancy), 32'd4);

        // Flush a full pipe while offering a valid word
        flush = 1'b1;
        din = 8'hFF;
        din_valid = 1'b1;
        step();
        flush = 1'b0;
        en = 1'b0;
        din_valid = 1'b0;
        check("flush_tap_valid", 32'(tap_valid), 32'h0);
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_taps", taps, 32'h10111213);

        // Bypass and out-of-range select
        delay_sel = 3'd0;
        din = 8'h3C;
        din_valid = 1'b1;
        #1;
        check("bypass_dout", 32'(dout), 32'h3C);
        check("bypass_valid", 32'(dout_valid), 32'd1);
        step();
        din = 8'hC3;
        din_valid = 1'b0;
        #1;
        check("bypass_dout2", 32'(dout), 32'hC3);
        check("bypass_valid2", 32'(dout_valid), 32'd0);
        step();
        delay_sel = 3'd5;
        #1;
        check("clamp_sel_err", 32'(sel_err), 32'd1);
        check("clamp_dout", 32'(dout), 32'h10);
        step();
        delay_sel = 3'd4;
        #1;
        check("sel4_sel_err", 32'(sel_err), 32'd0);

        // Reset mid-stream, with flush also asserted
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            din = 8'(8'h21 + j);
            din_valid = 1'b1;
            step();
        end
        rst_n = 1'b0;
        flush = 1'b1;
        step();
        rst_n = 1'b1;
        flush = 1'b0;
        en = 1'b0;
        din_valid = 1'b0;
        check("mrst_taps", taps, 32'h0);
        check("mrst_tap_valid", 32'(tap_valid), 32'h0);
        check("mrst_occ", 32'(occupancy), 32'd0);

`ifdef PIPE_DELAY_PARITY_EN
        en = 1'b1;
        din = 8'h31;
        din_valid = 1'b1;
        step();
        din = 8'h32;
        step();
        en = 1'b0;
        din_valid = 1'b0;
        delay_sel = 3'd2;
        step();
        check("par_clean", 32'(parity_err), 32'd0);
        cmp_off = 1'b1;
        force dut.g_stage[1].u_stage.r_data = 8'h30;
        step();
        check("par_set", 32'(parity_err), 32'd1);
        step();
        check("par_sticky", 32'(parity_err), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("par_flush_clr", 32'(parity_err), 32'd0);
        release dut.g_stage[1].u_stage.r_data;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        cmp_off = 1'b0;
`endif

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
